systolic_skew_feeder: RTL and testbench

Upstream operand feeder for one edge (left or top) of an N-lane systolic PE array. It accepts one N-element operand vector per cycle through a valid/ready handshake. It emits the vector diagonally skewed: lane j is delayed j extra cycles, so operands meet correctly inside the array. Idle and flush slots are zero-filled, so the PE multiply-accumulate is unaffected (0*x = 0). One instance feeds the rows and a second instance feeds the columns.

---
 rtl/systolic_pkg.sv | 19 +
 rtl/systolic_skew_feeder_delay.sv | 27 ++
 rtl/systolic_skew_feeder.sv | 123 ++++++++++++
 tb/tb_systolic_skew_feeder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic skew feeder.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } feeder_state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_N          = 4;

    // Bit offset of lane j inside a packed N*W lane vector.
    function automatic int lane_lsb(input int j, input int w);
        return j * w;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_delay.sv
// Fixed-depth operand delay line; synchronous reset clears every stage to zero.
module skew_delay_line #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] stage_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Diagonal-skew operand feeder for one edge of an N-lane systolic array.
// Optional FEEDER_BEAT_CNT_EN adds a saturating 16-bit frame beat counter (beat_cnt_o).
//
// state  | meaning
// IDLE   | waiting for the first beat of a frame
// STREAM | frame in progress, accepting beats
// FLUSH  | last beat taken, draining the skew with zeros
// DONE   | last beat's final element is on lane N-1
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N          = DEF_N
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N*DATA_WIDTH-1:0] vec_i,
    input  logic                    valid_i,
    input  logic                    last_i,
    output logic                    ready_o,
    output logic [N*DATA_WIDTH-1:0] lanes_o,
    output logic                    busy_o,
    output logic                    done_o
`ifdef FEEDER_BEAT_CNT_EN
    ,output logic [15:0]            beat_cnt_o
`endif
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    feeder_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic ready_q, busy_q, done_q;
    logic accept;

    assign accept = valid_i && ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    if (last_i) begin
                        // A single lane has no skew to drain, so go straight to DONE.
                        state_d = (N == 1) ? DONE : FLUSH;
                        cnt_d   = CNT_W'(N - 1);
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            FLUSH: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == IDLE) || (state_d == STREAM);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

    for (genvar j = 0; j < N; j++) begin : g_lane
        logic [DATA_WIDTH-1:0] lane_in;

        // Cycles without an accepted beat inject zeros so the PE MAC sees 0*x.
        assign lane_in = accept ? vec_i[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH] : '0;

        skew_delay_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (j + 1)
        ) u_dly (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .d_i   (lane_in),
            .q_o   (lanes_o[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

`ifdef FEEDER_BEAT_CNT_EN
    logic [15:0] beat_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            beat_cnt_q <= accept ? 16'd1 : 16'd0;
        end else if (accept && (beat_cnt_q != 16'hFFFF)) begin
            beat_cnt_q <= beat_cnt_q + 16'd1;
        end
    end

    assign beat_cnt_o = beat_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench: cycle table for the N=4 feeder plus hand sequences for reset and N=1.
module tb_systolic_skew_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] vec;
    logic        valid, last;
    logic        ready, busy, done;
    logic [31:0] lanes;
    logic [7:0]  vec1;
    logic        valid1, last1;
    logic        ready1, busy1, done1;
    logic [7:0]  lanes1;
`ifdef FEEDER_BEAT_CNT_EN
    logic [15:0] bcnt, bcnt1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.DATA_WIDTH(8), .N(4)) u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .vec_i   (vec),
        .valid_i (valid),
        .last_i  (last),
        .ready_o (ready),
        .lanes_o (lanes),
        .busy_o  (busy),
        .done_o  (done)
`ifdef FEEDER_BEAT_CNT_EN
        ,.beat_cnt_o (bcnt)
`endif
    );

    systolic_skew_feeder #(.DATA_WIDTH(8), .N(1)) u_dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .vec_i   (vec1),
        .valid_i (valid1),
        .last_i  (last1),
        .ready_o (ready1),
        .lanes_o (lanes1),
        .busy_o  (busy1),
        .done_o  (done1)
`ifdef FEEDER_BEAT_CNT_EN
        ,.beat_cnt_o (bcnt1)
`endif
    );

    typedef struct {
        logic        valid;
        logic        last;
        logic [31:0] vec;
        logic [31:0] lanes;
        logic        ready;
        logic        busy;
        logic        done;
    } vec_row_t;

    vec_row_t tbl[$];

    function automatic vec_row_t row(input logic v, input logic l, input logic [31:0] d,
                                     input logic [31:0] ln, input logic r, input logic b,
                                     input logic dn);
        vec_row_t x;
        x.valid = v; x.last = l; x.vec = d;
        x.lanes = ln; x.ready = r; x.busy = b; x.done = dn;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [31:0] ln, input logic r,
                          input logic b, input logic dn);
        check({tag, " lanes"}, lanes, ln);
        check({tag, " ready"}, {31'd0, ready}, {31'd0, r});
        check({tag, " busy"},  {31'd0, busy},  {31'd0, b});
        check({tag, " done"},  {31'd0, done},  {31'd0, dn});
    endtask

    task automatic check1(input string tag, input logic [7:0] ln, input logic r,
                          input logic b, input logic dn);
        check({tag, " lanes"}, {24'd0, lanes1}, {24'd0, ln});
        check({tag, " ready"}, {31'd0, ready1}, {31'd0, r});
        check({tag, " busy"},  {31'd0, busy1},  {31'd0, b});
        check({tag, " done"},  {31'd0, done1},  {31'd0, dn});
    endtask

    initial begin
        // Basic skew: single-beat frame.
        tbl.push_back(row(1, 1, 32'h44332211, 32'h00000000, 1, 0, 0));
        tbl.push_back(row(0, 0, 32'h0,        32'h00000011, 0, 1, 0));
        tbl.push_back(row(0, 0, 32'h0,        32'h00002200, 0, 1, 0));
        tbl.push_back(row(0, 0, 32'h0,        32'h00330000, 0, 1, 0));
        tbl.push_back(row(0, 0, 32'h0,        32'h44000000, 0, 1, 1));
        // Back-to-back four-beat frame; beat k element j = 0x10*(j+1)+k.
        tbl.push_back(row(1, 0, 32'h41312111, 32'h00000000, 1, 0, 0));
        tbl.push_back(row(1, 0, 32'h42322212, 32'h00000011, 1, 1, 0));
        tbl.push_back(row(1, 0, 32'h43332313, 32'h00002112, 1, 1, 0));
        tbl.push_back(row(1, 1, 32'h44342414, 32'h00312213, 1, 1, 0));
        tbl.push_back(row(0, 0, 32'h0,        32'h41322314, 0, 1, 0));
        tbl.push_back(row(0, 0, 32'h0,        32'h42332400, 0, 1, 0));
        tbl.push_back(row(0, 0, 32'h0,        32'h43340000, 0, 1, 0));
        tbl.push_back(row(0, 0, 32'h0,        32'h44000000, 0, 1, 1));
        tbl.push_back(row(0, 0, 32'h0,        32'h00000000, 1, 0, 0));
        // Two bubbles mid-frame, then 0xFF offered while flushing (must be refused).
        tbl.push_back(row(1, 0, 32'h45352515, 32'h00000000, 1, 0, 0));
        tbl.push_back(row(0, 0, 32'h0,        32'h00000015, 1, 1, 0));
        tbl.push_back(row(0, 1, 32'h0,        32'h00002500, 1, 1, 0));
        tbl.push_back(row(1, 1, 32'h46362616, 32'h00350000, 1, 1, 0));
        tbl.push_back(row(1, 1, 32'hFFFFFFFF, 32'h45000016, 0, 1, 0));
        tbl.push_back(row(1, 0, 32'hFFFFFFFF, 32'h00002600, 0, 1, 0));
        tbl.push_back(row(1, 1, 32'hFFFFFFFF, 32'h00360000, 0, 1, 0));
        tbl.push_back(row(0, 0, 32'h0,        32'h46000000, 0, 1, 1));
        // last_i without valid_i in IDLE is ignored.
        tbl.push_back(row(0, 1, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0));
        tbl.push_back(row(0, 0, 32'h0,        32'h00000000, 1, 0, 0));

        rst = 1'b1; vec = '0; valid = 1'b0; last = 1'b0;
        vec1 = '0; valid1 = 1'b0; last1 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check4("reset", 32'h0, 1, 0, 0);
        check1("reset n1", 8'h00, 1, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            valid = tbl[i].valid; last = tbl[i].last; vec = tbl[i].vec;
            #1;
            check4($sformatf("row%0d", i), tbl[i].lanes, tbl[i].ready, tbl[i].busy, tbl[i].done);
        end

        // Reset during FLUSH: pipeline cleared, no done pulse afterwards.
        @(negedge clk);
        valid = 1'b1; last = 1'b1; vec = 32'hDEADBEEF;
        @(negedge clk);
        valid = 1'b0; last = 1'b0; vec = '0;
        #1;
        check4("rst pre", 32'h000000EF, 0, 1, 0);
`ifdef FEEDER_BEAT_CNT_EN
        check("rst pre cnt", {16'd0, bcnt}, 32'd1);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check4("rst post", 32'h0, 1, 0, 0);
`ifdef FEEDER_BEAT_CNT_EN
        check("rst post cnt", {16'd0, bcnt}, 32'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check4($sformatf("rst drain%0d", i), 32'h0, 1, 0, 0);
        end

        // N=1: done coincides with the element on lane 0.
        @(negedge clk);
        valid1 = 1'b1; last1 = 1'b1; vec1 = 8'hAB;
        @(negedge clk);
        valid1 = 1'b0; last1 = 1'b0; vec1 = 8'h00;
        #1;
        check1("n1 single", 8'hAB, 0, 1, 1);
        @(negedge clk);
        #1;
        check1("n1 idle", 8'h00, 1, 0, 0);
        valid1 = 1'b1; last1 = 1'b0; vec1 = 8'h01;
        @(negedge clk);
        valid1 = 1'b1; last1 = 1'b1; vec1 = 8'h02;
        #1;
        check1("n1 beat1", 8'h01, 1, 1, 0);
        @(negedge clk);
        valid1 = 1'b0; last1 = 1'b0; vec1 = 8'h00;
        #1;
        check1("n1 beat2", 8'h02, 0, 1, 1);
        @(negedge clk);
        #1;
        check1("n1 end", 8'h00, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
